// File: rtl/io_port_unit.sv
// Purpose : 4 KB big-endian byte-addressed I/O memory plus a periodic interrupt source with intr/inta handshake.
// Latency : reads are combinational (zero cycles); writes land at the clock edge; intr rises INTR_PERIOD edges after reset/ack.
// Backpr. : none on the bus; intr is held until inta is seen, then the source waits for inta to drop before recounting.
module io_port_unit #(
  parameter int ADDR_BITS   = 12,
  parameter int INTR_PERIOD = 200,
  parameter bit INTR_EN     = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        io_cs,
  input  logic        io_rd,
  input  logic        io_wr,
  input  logic [31:0] io_address,
  input  logic [31:0] io_d_in,
  output logic [31:0] io_out,
  output logic        intr,
  input  logic        inta
);

  localparam int DEPTH = 2 ** ADDR_BITS;
  localparam int CW    = $clog2(INTR_PERIOD + 1);
  localparam logic [CW-1:0] CNT_LOAD = CW'(INTR_PERIOD);

  typedef enum logic [1:0] {
    ST_COUNT = 2'd0,
    ST_REQ   = 2'd1,
    ST_ACK   = 2'd2
  } state_t;

  // Byte storage; named M so simulation can preload it hierarchically.
  logic [7:0] M [0:DEPTH-1];

  logic [ADDR_BITS-1:0] w_a0, w_a1, w_a2, w_a3;
  logic [31:0]          w_word;
  logic                 w_wr_en;
  logic                 w_addr_unused;

  // Four consecutive byte addresses; the adds wrap naturally at the top of the space.
  assign w_a0 = io_address[ADDR_BITS-1:0];
  assign w_a1 = w_a0 + ADDR_BITS'(1);
  assign w_a2 = w_a0 + ADDR_BITS'(2);
  assign w_a3 = w_a0 + ADDR_BITS'(3);

  // Upper address bits are not decoded.
  assign w_addr_unused = ^io_address[31:ADDR_BITS];

  assign w_word  = {M[w_a0], M[w_a1], M[w_a2], M[w_a3]};
  assign w_wr_en = reset & io_cs & io_wr;

  // Read path reflects the pre-edge contents, so rd+wr in one cycle returns the old word.
  assign io_out = (io_cs && io_rd) ? w_word : 32'hZZZZ_ZZZZ;

  // Big-endian word write; memory is never cleared, and a low reset at the edge blocks the write.
  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      M[w_a0] <= io_d_in[31:24];
      M[w_a1] <= io_d_in[23:16];
      M[w_a2] <= io_d_in[15:8];
      M[w_a3] <= io_d_in[7:0];
    end
  end

  state_t          r_state, w_state_nxt;
  logic [CW-1:0]   r_cnt, w_cnt_nxt;
  logic            r_intr;

  // Next-state logic: count down, request, then wait for the acknowledge to be released.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    if (INTR_EN == 1'b0) begin
      w_state_nxt = ST_COUNT;
      w_cnt_nxt   = CNT_LOAD;
    end else begin
      case (r_state)
        ST_COUNT: begin
          // Reaching zero on this edge raises the request on the same edge.
          if (r_cnt <= CW'(1)) begin
            w_cnt_nxt   = '0;
            w_state_nxt = ST_REQ;
          end else begin
            w_cnt_nxt = r_cnt - CW'(1);
          end
        end
        ST_REQ: begin
          if (inta) w_state_nxt = ST_ACK;
        end
        ST_ACK: begin
          if (!inta) begin
            w_cnt_nxt   = CNT_LOAD;
            w_state_nxt = ST_COUNT;
          end
        end
        default: begin
          w_state_nxt = ST_COUNT;
          w_cnt_nxt   = CNT_LOAD;
        end
      endcase
    end
  end

  // State, counter and registered intr; intr tracks the next state so it is glitch-free.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_COUNT;
      r_cnt   <= CNT_LOAD;
      r_intr  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_intr  <= (w_state_nxt == ST_REQ);
    end
  end

  assign intr = r_intr;

endmodule

// File: tb/tb_io_port_unit.sv
// Directed bench for io_port_unit: memory write/read, byte order, wrap, bus idle, rd+wr, interrupt timing, reset abort.
// The read bus is a pulled-up net, so an undriven (Z) bus reads back as all ones.
module tb_io_port_unit;

  logic        clk;
  logic        reset;
  logic        io_cs;
  logic        io_rd;
  logic        io_wr;
  logic [31:0] io_address;
  logic [31:0] io_d_in;
  tri1  [31:0] io_out;
  logic        intr;
  logic        inta;

  int n_tests;
  int n_fail;

  io_port_unit #(
    .ADDR_BITS  (12),
    .INTR_PERIOD(5),
    .INTR_EN    (1'b1)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .io_cs     (io_cs),
    .io_rd     (io_rd),
    .io_wr     (io_wr),
    .io_address(io_address),
    .io_d_in   (io_d_in),
    .io_out    (io_out),
    .intr      (intr),
    .inta      (inta)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, act, exp);
    end
  endtask

  task automatic bus_wr(input logic [31:0] addr, input logic [31:0] data);
    @(negedge clk);
    io_address = addr;
    io_d_in    = data;
    io_cs      = 1'b1;
    io_wr      = 1'b1;
    io_rd      = 1'b0;
    @(posedge clk);
    #1;
    io_cs = 1'b0;
    io_wr = 1'b0;
  endtask

  task automatic bus_rd(input string tag, input logic [31:0] addr, input logic [31:0] exp);
    @(negedge clk);
    io_address = addr;
    io_cs      = 1'b1;
    io_rd      = 1'b1;
    io_wr      = 1'b0;
    #2;
    chk(tag, io_out, exp);
    io_cs = 1'b0;
    io_rd = 1'b0;
  endtask

  initial begin
    logic ok;
    n_tests    = 0;
    n_fail     = 0;
    reset      = 1'b0;
    io_cs      = 1'b0;
    io_rd      = 1'b0;
    io_wr      = 1'b0;
    io_address = '0;
    io_d_in    = '0;
    inta       = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    chk("rst_intr", intr, 0);
    chk("rst_bus_idle", io_out, 32'hFFFF_FFFF);

    // First request: intr rises exactly on the 5th edge after release
    @(negedge clk);
    reset = 1'b1;
    ok = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      @(posedge clk);
      #1;
      if (i < 5) ok = ok & (intr == 1'b0);
    end
    chk("intr_low_while_count", ok, 1);
    chk("intr_rise_5th_edge", intr, 1);

    // Request is held while inta stays low
    ok = 1'b1;
    repeat (20) begin
      @(posedge clk);
      #1;
      ok = ok & (intr == 1'b1);
    end
    chk("intr_hold_no_ack", ok, 1);

    // One-clock inta pulse: intr drops on that edge, returns after ACK exit + 5 edges
    @(negedge clk);
    inta = 1'b1;
    @(posedge clk);
    #1;
    chk("intr_drop_on_ack", intr, 0);
    @(negedge clk);
    inta = 1'b0;
    ok = 1'b1;
    for (int i = 2; i <= 7; i++) begin
      @(posedge clk);
      #1;
      if (i < 7) ok = ok & (intr == 1'b0);
      // inta raised during counting must be ignored
      if (i == 3) begin
        @(negedge clk);
        inta = 1'b1;
      end
      if (i == 4) begin
        @(negedge clk);
        inta = 1'b0;
      end
    end
    chk("intr_low_after_ack", ok, 1);
    chk("intr_rerise", intr, 1);

    // Write/read and byte order (intr stays requested meanwhile)
    bus_wr(32'h0000_0014, 32'h9C00_0000);
    bus_wr(32'h0000_0010, 32'h1234_5678);
    bus_rd("rd_010", 32'h0000_0010, 32'h1234_5678);
    bus_rd("rd_011_misaligned", 32'h0000_0011, 32'h3456_789C);
    chk("byte_M010", {24'h0, dut.M[12'h010]}, 32'h12);
    chk("byte_M013", {24'h0, dut.M[12'h013]}, 32'h78);
    bus_rd("rd_upper_addr_ignored", 32'hABCD_E010, 32'h1234_5678);

    // Preloaded low bytes read back big-endian
    bus_wr(32'h0000_0000, 32'h0123_4567);
    chk("byte_M000", {24'h0, dut.M[12'h000]}, 32'h01);
    chk("byte_M003", {24'h0, dut.M[12'h003]}, 32'h67);
    bus_rd("rd_000", 32'h0000_0000, 32'h0123_4567);

    // Address wrap at the top of the space
    bus_wr(32'h0000_0FFE, 32'hAABB_CCDD);
    chk("wrap_MFFE", {24'h0, dut.M[12'hFFE]}, 32'hAA);
    chk("wrap_MFFF", {24'h0, dut.M[12'hFFF]}, 32'hBB);
    chk("wrap_M000", {24'h0, dut.M[12'h000]}, 32'hCC);
    chk("wrap_M001", {24'h0, dut.M[12'h001]}, 32'hDD);
    bus_rd("rd_FFE", 32'h0000_0FFE, 32'hAABB_CCDD);
    bus_rd("rd_000_after_wrap", 32'h0000_0000, 32'hCCDD_4567);

    // Bus idle cases
    @(negedge clk);
    io_address = 32'h0000_0010;
    io_cs = 1'b0;
    io_rd = 1'b1;
    #2;
    chk("idle_cs0", io_out, 32'hFFFF_FFFF);
    io_cs = 1'b1;
    io_rd = 1'b0;
    #2;
    chk("idle_rd0", io_out, 32'hFFFF_FFFF);
    io_cs = 1'b0;

    // No write without cs, and none without wr
    @(negedge clk);
    io_address = 32'h0000_0010;
    io_d_in    = 32'hFFFF_FFFF;
    io_cs      = 1'b0;
    io_wr      = 1'b1;
    @(posedge clk);
    #1;
    io_cs = 1'b1;
    io_wr = 1'b0;
    @(posedge clk);
    #1;
    io_cs = 1'b0;
    bus_rd("no_write_idle", 32'h0000_0010, 32'h1234_5678);

    // rd+wr in one cycle: old word before the edge, new word after
    bus_wr(32'h0000_0030, 32'hDEAD_BEEF);
    @(negedge clk);
    io_address = 32'h0000_0030;
    io_d_in    = 32'hCAFE_F00D;
    io_cs      = 1'b1;
    io_rd      = 1'b1;
    io_wr      = 1'b1;
    #2;
    chk("rdwr_pre_edge", io_out, 32'hDEAD_BEEF);
    @(posedge clk);
    #1;
    chk("rdwr_post_edge", io_out, 32'hCAFE_F00D);
    io_wr = 1'b0;
    io_rd = 1'b0;
    io_cs = 1'b0;

    // Reset abort: intr drops immediately, write during reset is suppressed
    chk("intr_before_abort", intr, 1);
    @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    chk("abort_intr_drop", intr, 0);
    io_address = 32'h0000_0010;
    io_d_in    = 32'hFFFF_FFFF;
    io_cs      = 1'b1;
    io_wr      = 1'b1;
    @(posedge clk);
    #1;
    chk("abort_no_write", {24'h0, dut.M[12'h010]}, 32'h12);
    @(negedge clk);
    io_cs = 1'b0;
    io_wr = 1'b0;
    reset = 1'b1;
    ok = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      @(posedge clk);
      #1;
      if (i < 5) ok = ok & (intr == 1'b0);
    end
    chk("abort_intr_low_count", ok, 1);
    chk("abort_intr_rerise", intr, 1);
    bus_rd("abort_mem_kept", 32'h0000_0010, 32'h1234_5678);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
